tlul_host_arb: RTL and testbench



---
 rtl/tlul_arb_pkg.sv | 38 +++
 rtl/tlul_arb_tag_fifo.sv | 60 ++++++
 rtl/tlul_host_arb.sv | 119 +++++++++++
 tb/tb_tlul_host_arb.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlul_arb_pkg.sv
// Shared types for the TL-UL host arbiter: simplified TL-UL channel structs,
// the host-index tag type and sizing limits.
package tlul_arb_pkg;

  localparam int ArbMaxHosts = 4;
  localparam int ArbMaxDepth = 16;

  typedef logic [1:0] arb_idx_t;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  function automatic logic [ArbMaxHosts-1:0] arb_onehot(input arb_idx_t idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/tlul_arb_tag_fifo.sv
// In-order tag FIFO holding the host index of each accepted request until its
// response has been delivered. Head is read combinationally.
module tlul_arb_tag_fifo
  import tlul_arb_pkg::*;
#(
  parameter  int Depth = 4,
  localparam int CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push,
  input  arb_idx_t        wdata,
  input  logic            pop,
  output logic            full,
  output logic            empty,
  output arb_idx_t        head,
  output logic [CntW-1:0] count
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  arb_idx_t        mem [Depth];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tlul_host_arb.sv
// M:1 TL-UL host arbiter with grant lock and in-order response steering.
// Define TLUL_HOST_ARB_FIXED_PRIO_EN for fixed lowest-index-first priority.
module tlul_host_arb
  import tlul_arb_pkg::*;
#(
  parameter  int M        = 2,
  parameter  int OutDepth = 4,
  localparam int IdxW     = $clog2(M),
  localparam int CntW     = $clog2(OutDepth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  tl_h2d_t         tl_h_i [M],
  output tl_d2h_t         tl_h_o [M],
  output tl_h2d_t         tl_d_o,
  input  tl_d2h_t         tl_d_i,
  output logic [M-1:0]    gnt_o,
  output logic [CntW-1:0] outstanding_o
);

  logic [IdxW-1:0] rr_ptr;
  logic            lock_q;
  logic [IdxW-1:0] lock_idx_q;

  logic            has_grant;
  logic [IdxW-1:0] grant_idx;
  logic [IdxW-1:0] rr_next;
  logic [IdxW-1:0] head_idx;
  logic            dev_a_valid;
  logic            accept;
  logic            dev_d_ready;
  logic            pop;

  logic            fifo_full;
  logic            fifo_empty;
  arb_idx_t        fifo_head;
  logic [CntW-1:0] fifo_count;

  // A held lock wins; otherwise scan from rr_ptr for the first requester.
  always_comb begin
    has_grant = 1'b0;
    grant_idx = '0;
    if (lock_q) begin
      has_grant = 1'b1;
      grant_idx = lock_idx_q;
    end else begin
      for (int i = 0; i < M; i++) begin
        if (!has_grant && tl_h_i[(int'(rr_ptr) + i) % M].a_valid) begin
          has_grant = 1'b1;
          grant_idx = IdxW'((int'(rr_ptr) + i) % M);
        end
      end
    end
  end

  assign rr_next     = IdxW'((int'(grant_idx) + 1) % M);
  assign head_idx    = IdxW'(fifo_head);
  assign dev_a_valid = ~rst_i & has_grant & tl_h_i[grant_idx].a_valid & ~fifo_full;
  assign accept      = dev_a_valid & tl_d_i.a_ready;
  assign dev_d_ready = ~rst_i & ~fifo_empty & tl_h_i[head_idx].d_ready;
  assign pop         = tl_d_i.d_valid & dev_d_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (accept) begin
      lock_q <= 1'b0;
`ifdef TLUL_HOST_ARB_FIXED_PRIO_EN
      rr_ptr <= '0;
`else
      rr_ptr <= rr_next;
`endif
    end else if (dev_a_valid) begin
      // Beat is on the wire but stalled: pin the grant until it is taken.
      lock_q     <= 1'b1;
      lock_idx_q <= grant_idx;
    end
  end

  tlul_arb_tag_fifo #(
    .Depth (OutDepth)
  ) u_tag_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (accept),
    .wdata (arb_idx_t'(grant_idx)),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head),
    .count (fifo_count)
  );

  always_comb begin
    tl_d_o         = tl_h_i[grant_idx];
    tl_d_o.a_valid = dev_a_valid;
    tl_d_o.d_ready = dev_d_ready;
  end

  always_comb begin
    for (int i = 0; i < M; i++) begin
      tl_h_o[i]         = tl_d_i;
      tl_h_o[i].a_ready = ~rst_i & has_grant & (grant_idx == IdxW'(i))
                          & tl_d_i.a_ready & ~fifo_full;
      tl_h_o[i].d_valid = ~rst_i & ~fifo_empty & (head_idx == IdxW'(i))
                          & tl_d_i.d_valid;
    end
  end

  assign gnt_o         = (rst_i || !has_grant) ? '0 : M'(arb_onehot(arb_idx_t'(grant_idx)));
  assign outstanding_o = rst_i ? '0 : fifo_count;

  // A response with no recorded tag has no owner and is never acknowledged.
  d_valid_without_tag: assert property (
    @(posedge clk_i) disable iff (rst_i) !(tl_d_i.d_valid && fifo_empty));

endmodule

// File: tb/tb_tlul_host_arb.sv
// Randomized self-checking bench for tlul_host_arb (M=2, OutDepth=4) with a
// queue-based reference model plus directed scenarios pinned by literals.
module tb_tlul_host_arb;
  import tlul_arb_pkg::*;

  localparam int M = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  tl_h2d_t      h_req [M];
  tl_d2h_t      h_rsp [M];
  tl_h2d_t      d_req;
  tl_d2h_t      d_rsp;
  logic [M-1:0] gnt;
  logic [2:0]   outst;

  always #5 clk = ~clk;

  tlul_host_arb #(.M(M), .OutDepth(D)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .tl_h_i        (h_req),
    .tl_h_o        (h_rsp),
    .tl_d_o        (d_req),
    .tl_d_i        (d_rsp),
    .gnt_o         (gnt),
    .outstanding_o (outst)
  );

  int checks = 0;
  int errors = 0;

  // stimulus state
  bit          req_v [M];
  logic [31:0] req_addr [M];
  logic [31:0] req_data [M];
  bit          h_dr [M];
  bit          dev_ar;
  bit          dev_dv;
  logic [31:0] dev_data;

  // reference model: next host to favour, pinned host, outstanding tags
  int rr = 0;
  bit lk = 0;
  int lk_h = 0;
  int q[$];

  // observations from the last checked cycle
  logic [M-1:0] obs_gnt;
  bit           obs_acc;
  bit           obs_dav;
  bit           obs_dr;
  logic [2:0]   obs_out;
  logic [M-1:0] obs_dv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < M; i++) begin
      h_req[i]           = '0;
      h_req[i].a_valid   = req_v[i];
      h_req[i].a_address = req_addr[i];
      h_req[i].a_data    = req_data[i];
      h_req[i].a_source  = 8'(i);
      h_req[i].a_mask    = 4'hf;
      h_req[i].d_ready   = h_dr[i];
    end
    d_rsp         = '0;
    d_rsp.a_ready = dev_ar;
    d_rsp.d_valid = dev_dv;
    d_rsp.d_data  = dev_data;
  endtask

  task automatic rand_inputs(input int p_req, input int p_ar, input int p_dv, input int p_dr);
    for (int i = 0; i < M; i++) begin
      if (!req_v[i] && $urandom_range(99) < p_req) begin
        req_v[i]    = 1'b1;
        req_addr[i] = $urandom;
        req_data[i] = $urandom;
      end
      h_dr[i] = ($urandom_range(99) < p_dr);
    end
    dev_ar   = ($urandom_range(99) < p_ar);
    dev_dv   = (q.size() > 0) && ($urandom_range(99) < p_dv);
    dev_data = $urandom;
  endtask

  // Called at posedge+1 with inputs driven; checks at negedge, returns at next posedge+1.
  task automatic step();
    bit full, empty, has, exp_dav, acc, exp_dr, pop, exp_dv;
    int g, hh;
    #4;
    full  = (q.size() == D);
    empty = (q.size() == 0);
    has = 0;
    g   = 0;
    if (lk) begin
      has = 1;
      g   = lk_h;
    end else begin
      for (int k = 0; k < M; k++) begin
        int c;
        c = (rr + k) % M;
        if (!has && req_v[c]) begin
          has = 1;
          g   = c;
        end
      end
    end
    exp_dav = has && req_v[g] && !full;
    acc     = exp_dav && dev_ar;
    hh      = empty ? 0 : q[0];
    exp_dr  = !empty && h_dr[hh];
    pop     = dev_dv && exp_dr;

    chk("gnt", gnt, has ? (64'd1 << g) : 64'd0);
    chk("dev_a_valid", d_req.a_valid, exp_dav);
    if (exp_dav) begin
      chk("dev_a_address", d_req.a_address, req_addr[g]);
      chk("dev_a_data", d_req.a_data, req_data[g]);
    end
    chk("dev_d_ready", d_req.d_ready, exp_dr);
    chk("outstanding", outst, q.size());
    for (int i = 0; i < M; i++) begin
      chk("host_a_ready", h_rsp[i].a_ready, has && (i == g) && dev_ar && !full);
      exp_dv = !empty && (i == hh) && dev_dv;
      chk("host_d_valid", h_rsp[i].d_valid, exp_dv);
      if (exp_dv) chk("host_d_data", h_rsp[i].d_data, dev_data);
    end

    obs_gnt = gnt;
    obs_acc = d_req.a_valid && d_rsp.a_ready;
    obs_dav = d_req.a_valid;
    obs_dr  = d_req.d_ready;
    obs_out = outst;
    for (int i = 0; i < M; i++) obs_dv[i] = h_rsp[i].d_valid;

    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (acc) begin
      q.push_back(g);
      rr       = (g + 1) % M;
      lk       = 0;
      req_v[g] = 0;
    end else if (exp_dav) begin
      lk   = 1;
      lk_h = g;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 with reset released and model cleared.
  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < M; i++) begin
      req_v[i] = 1'b1;
      h_dr[i]  = 1'b1;
    end
    dev_ar = 1'b1;
    dev_dv = 1'b1;
    drive();
    #2;
    chk("rst_gnt", gnt, 0);
    chk("rst_dev_a_valid", d_req.a_valid, 0);
    chk("rst_dev_d_ready", d_req.d_ready, 0);
    chk("rst_outstanding", outst, 0);
    for (int i = 0; i < M; i++) begin
      chk("rst_host_a_ready", h_rsp[i].a_ready, 0);
      chk("rst_host_d_valid", h_rsp[i].d_valid, 0);
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    q.delete();
    rr = 0;
    lk = 0;
    lk_h = 0;
    for (int i = 0; i < M; i++) req_v[i] = 1'b0;
    dev_ar = 1'b0;
    dev_dv = 1'b0;
    drive();
    rst = 1'b0;
  endtask

  initial begin
    int seq[$];
    int acc_h [M];
    int n_acc;

    for (int i = 0; i < M; i++) begin
      req_v[i] = 0; req_addr[i] = '0; req_data[i] = '0; h_dr[i] = 0; acc_h[i] = 0;
    end
    dev_ar = 0; dev_dv = 0; dev_data = '0;
    drive();
    @(posedge clk);
    #1;
    do_reset();

    // Both hosts always requesting, device always ready: strict alternation.
    repeat (100) begin
      rand_inputs(100, 100, 100, 100);
      drive();
      step();
      if (obs_acc) begin
        seq.push_back(int'(obs_gnt));
        if (obs_gnt == 2'b01) acc_h[0]++;
        if (obs_gnt == 2'b10) acc_h[1]++;
      end
    end
    chk("alt_accepts", seq.size(), 100);
    if (seq.size() >= 4) begin
      chk("alt_g0", seq[0], 1);
      chk("alt_g1", seq[1], 2);
      chk("alt_g2", seq[2], 1);
      chk("alt_g3", seq[3], 2);
    end
    chk("share_h0", acc_h[0], 50);
    chk("share_h1", acc_h[1], 50);

    // Grant lock: host 1 stalled while host 0 (favoured by rr) requests.
    do_reset();
    req_v[1] = 1; req_addr[1] = 32'h1000_0010; req_data[1] = 32'hA5A5_0001;
    dev_ar = 0;
    drive();
    step();
    chk("lock_first_gnt", obs_gnt, 2'b10);
    req_v[0] = 1; req_addr[0] = 32'h2000_0020; req_data[0] = 32'h5A5A_0002;
    repeat (3) begin
      drive();
      step();
      chk("lock_hold_gnt", obs_gnt, 2'b10);
      chk("lock_no_accept", obs_acc, 0);
    end
    dev_ar = 1;
    drive();
    step();
    chk("lock_accept", obs_acc, 1);
    chk("lock_accept_gnt", obs_gnt, 2'b10);
    drive();
    step();
    chk("after_lock_gnt", obs_gnt, 2'b01);

    // Full FIFO: six attempts, no responses.
    do_reset();
    n_acc = 0;
    repeat (6) begin
      rand_inputs(100, 100, 0, 100);
      drive();
      step();
      if (obs_acc) n_acc++;
    end
    chk("full_accepts", n_acc, 4);
    chk("full_outstanding", obs_out, 4);
    chk("full_dev_a_valid", obs_dav, 0);
    rand_inputs(100, 100, 100, 100);
    drive();
    step();
    chk("full_pop_no_accept", obs_acc, 0);
    rand_inputs(100, 100, 0, 100);
    drive();
    step();
    chk("full_after_pop_accept", obs_acc, 1);
    chk("full_after_pop_out", obs_out, 3);

    // Response steering in tag order 0,1,1,0 with a host-1 stall.
    do_reset();
    dev_ar = 1;
    for (int k = 0; k < 4; k++) begin
      int h;
      h = (k == 1 || k == 2) ? 1 : 0;
      req_v[h] = 1; req_addr[h] = $urandom; req_data[h] = $urandom;
      drive();
      step();
    end
    chk("order_outstanding", outst, 4);
    dev_ar = 0; dev_dv = 1; h_dr[0] = 1; h_dr[1] = 1; dev_data = 32'hD000_0000;
    drive(); step();
    chk("order_r0_dv", obs_dv, 2'b01);
    h_dr[1] = 0; dev_data = 32'hD000_0001;
    drive(); step();
    chk("order_stall_dv", obs_dv, 2'b10);
    chk("order_stall_dr", obs_dr, 0);
    h_dr[1] = 1;
    drive(); step();
    chk("order_r1_dv", obs_dv, 2'b10);
    drive(); step();
    chk("order_r2_dv", obs_dv, 2'b10);
    dev_data = 32'hD000_0003;
    drive(); step();
    chk("order_r3_dv", obs_dv, 2'b01);
    chk("order_drained", q.size(), 0);
    dev_dv = 0;

    // Push and pop in the same cycle at occupancy 2.
    dev_ar = 1;
    repeat (2) begin
      req_v[0] = 1; req_addr[0] = $urandom; req_data[0] = $urandom;
      drive(); step();
    end
    req_v[1] = 1; req_addr[1] = $urandom; req_data[1] = $urandom;
    dev_dv = 1;
    drive(); step();
    chk("pp_occ_before", obs_out, 2);
    chk("pp_accept", obs_acc, 1);
    dev_ar = 0;
    drive(); step();
    chk("pp_occ_after", obs_out, 2);
    chk("pp_head0", obs_dv, 2'b01);
    drive(); step();
    chk("pp_head1", obs_dv, 2'b10);
    dev_dv = 0;

    // Reset with three outstanding requests and rr pointing at host 1.
    do_reset();
    repeat (3) begin
      rand_inputs(100, 100, 0, 100);
      drive(); step();
    end
    chk("mid_outstanding", outst, 3);
    do_reset();
    rand_inputs(100, 100, 0, 100);
    drive(); step();
    chk("post_rst_gnt", obs_gnt, 2'b01);
    chk("post_rst_out", obs_out, 0);

    // Long randomized run.
    repeat (3000) begin
      rand_inputs(60, 70, 60, 70);
      drive();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
